// File: rtl/result_reader_interface.sv
// result_reader_interface: captures done_sig/product results into a FIFO and serves them through a registered pop interface.
module result_reader_interface #(
  parameter int DATA_W    = 16,
  parameter int DEPTH     = 16,
  parameter int AFULL_LVL = 12
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       done_sig,
  input  logic [DATA_W-1:0]          product,
  input  logic                       read_req,
  input  logic                       err_clr,
  output logic [DATA_W-1:0]          fifo_read_data,
  output logic                       read_valid,
  output logic                       empty_out,
  output logic                       full_out,
  output logic                       afull_out,
  output logic [$clog2(DEPTH):0]     count,
  output logic                       overflow,
  output logic                       underflow
);
  localparam int AW = $clog2(DEPTH);
  logic [DATA_W-1:0] mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic pop, push;
  assign empty_out = count == '0;
  assign full_out  = count == (AW+1)'(DEPTH);
  assign afull_out = count >= (AW+1)'(AFULL_LVL);
  assign pop  = read_req && !empty_out;
  // A full FIFO still accepts a word when the same edge frees a slot.
  assign push = done_sig && (!full_out || pop);
  always_ff @(posedge clk)
    if (push) mem[wr_ptr] <= product;
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      wr_ptr         <= '0;
      rd_ptr         <= '0;
      count          <= '0;
      fifo_read_data <= '0;
      read_valid     <= 1'b0;
      overflow       <= 1'b0;
      underflow      <= 1'b0;
    end else begin
      wr_ptr     <= push ? wr_ptr + AW'(1) : wr_ptr;
      rd_ptr     <= pop ? rd_ptr + AW'(1) : rd_ptr;
      count      <= (push && !pop) ? count + (AW+1)'(1) : (pop && !push) ? count - (AW+1)'(1) : count;
      read_valid <= pop;
      if (pop) fifo_read_data <= mem[rd_ptr];
      overflow   <= (done_sig && !push) || (overflow && !err_clr);
      underflow  <= (read_req && empty_out) || (underflow && !err_clr);
    end
endmodule

// File: tb/tb_result_reader_interface.sv
// tb_result_reader_interface: directed scenario tests for result_reader_interface.
module tb_result_reader_interface;
  logic clk = 1'b0, rst = 1'b1, done_sig = 1'b0, read_req = 1'b0, err_clr = 1'b0;
  logic [15:0] product = '0;
  logic [15:0] fifo_read_data;
  logic read_valid, empty_out, full_out, afull_out, overflow, underflow;
  logic [4:0] count;
  int pass_cnt = 0, total_cnt = 0;

  result_reader_interface dut (
    .clk(clk), .rst(rst), .done_sig(done_sig), .product(product), .read_req(read_req),
    .err_clr(err_clr), .fifo_read_data(fifo_read_data), .read_valid(read_valid),
    .empty_out(empty_out), .full_out(full_out), .afull_out(afull_out), .count(count),
    .overflow(overflow), .underflow(underflow)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; done_sig = 1'b1; product = 16'h0005;
    step(); step();
    total_cnt++;
    if ({count, empty_out, full_out, afull_out} !== {5'd0, 3'b100}) $display("FAIL reset_status got %h exp %h", {count, empty_out, full_out, afull_out}, {5'd0, 3'b100});
    else pass_cnt++;
    total_cnt++;
    if ({fifo_read_data, read_valid, overflow, underflow} !== 19'd0) $display("FAIL reset_regs got %h exp %h", {fifo_read_data, read_valid, overflow, underflow}, 19'd0);
    else pass_cnt++;
    done_sig = 1'b0;
    rst = 1'b0;
    step();
  endtask

  task automatic test_single();
    done_sig = 1'b1; product = 16'h1234;
    step();
    done_sig = 1'b0;
    total_cnt++;
    if ({count, empty_out} !== {5'd1, 1'b0}) $display("FAIL single_push got %h exp %h", {count, empty_out}, {5'd1, 1'b0});
    else pass_cnt++;
    read_req = 1'b1;
    step();
    read_req = 1'b0;
    total_cnt++;
    if ({fifo_read_data, read_valid, count, empty_out} !== {16'h1234, 1'b1, 5'd0, 1'b1}) $display("FAIL single_pop got %h exp %h", {fifo_read_data, read_valid, count, empty_out}, {16'h1234, 1'b1, 5'd0, 1'b1});
    else pass_cnt++;
    step();
    total_cnt++;
    if ({fifo_read_data, read_valid} !== {16'h1234, 1'b0}) $display("FAIL single_hold got %h exp %h", {fifo_read_data, read_valid}, {16'h1234, 1'b0});
    else pass_cnt++;
  endtask

  task automatic test_fill_overflow();
    for (int i = 1; i <= 17; i++) begin
      done_sig = 1'b1; product = 16'(i);
      step();
      total_cnt++;
      if ({count, afull_out, full_out, overflow} !== {5'(i > 16 ? 16 : i), i >= 12, i >= 16, i == 17})
        $display("FAIL fill_%0d got %h exp %h", i, {count, afull_out, full_out, overflow}, {5'(i > 16 ? 16 : i), i >= 12, i >= 16, i == 17});
      else pass_cnt++;
    end
    done_sig = 1'b0;
    read_req = 1'b1;
    for (int i = 1; i <= 16; i++) begin
      step();
      total_cnt++;
      if ({fifo_read_data, read_valid} !== {16'(i), 1'b1}) $display("FAIL drain_%0d got %h exp %h", i, {fifo_read_data, read_valid}, {16'(i), 1'b1});
      else pass_cnt++;
    end
    read_req = 1'b0;
    step();
    total_cnt++;
    if ({empty_out, read_valid, fifo_read_data} !== {2'b10, 16'h0010}) $display("FAIL drain_end got %h exp %h", {empty_out, read_valid, fifo_read_data}, {2'b10, 16'h0010});
    else pass_cnt++;
    err_clr = 1'b1;
    step();
    err_clr = 1'b0;
    total_cnt++;
    if (overflow !== 1'b0) $display("FAIL ovf_clear got %b exp 0", overflow);
    else pass_cnt++;
  endtask

  task automatic test_simultaneous();
    for (int i = 0; i < 16; i++) begin
      done_sig = 1'b1; product = 16'h0100 + 16'(i);
      step();
    end
    product = 16'hBEEF; read_req = 1'b1;
    step();
    done_sig = 1'b0;
    total_cnt++;
    if ({overflow, count, full_out, fifo_read_data, read_valid} !== {1'b0, 5'd16, 1'b1, 16'h0100, 1'b1})
      $display("FAIL full_pushpop got %h exp %h", {overflow, count, full_out, fifo_read_data, read_valid}, {1'b0, 5'd16, 1'b1, 16'h0100, 1'b1});
    else pass_cnt++;
    for (int i = 1; i < 16; i++) begin
      step();
      total_cnt++;
      if (fifo_read_data !== 16'h0100 + 16'(i)) $display("FAIL full_drain_%0d got %h exp %h", i, fifo_read_data, 16'h0100 + 16'(i));
      else pass_cnt++;
    end
    step();
    read_req = 1'b0;
    total_cnt++;
    if ({fifo_read_data, read_valid, count} !== {16'hBEEF, 1'b1, 5'd0}) $display("FAIL beef_16th got %h exp %h", {fifo_read_data, read_valid, count}, {16'hBEEF, 1'b1, 5'd0});
    else pass_cnt++;
    done_sig = 1'b1; product = 16'hCAFE; read_req = 1'b1;
    step();
    done_sig = 1'b0;
    total_cnt++;
    if ({underflow, count, read_valid, fifo_read_data} !== {1'b1, 5'd1, 1'b0, 16'hBEEF})
      $display("FAIL empty_pushpop got %h exp %h", {underflow, count, read_valid, fifo_read_data}, {1'b1, 5'd1, 1'b0, 16'hBEEF});
    else pass_cnt++;
    step();
    read_req = 1'b0;
    total_cnt++;
    if ({fifo_read_data, read_valid, count} !== {16'hCAFE, 1'b1, 5'd0}) $display("FAIL empty_followup got %h exp %h", {fifo_read_data, read_valid, count}, {16'hCAFE, 1'b1, 5'd0});
    else pass_cnt++;
  endtask

  task automatic test_err_clr();
    err_clr = 1'b1; read_req = 1'b1;
    step();
    total_cnt++;
    if (underflow !== 1'b1) $display("FAIL clr_vs_set got %b exp 1", underflow);
    else pass_cnt++;
    read_req = 1'b0;
    step();
    err_clr = 1'b0;
    total_cnt++;
    if ({underflow, overflow} !== 2'b00) $display("FAIL clr_flags got %b exp 00", {underflow, overflow});
    else pass_cnt++;
  endtask

  task automatic test_wrap();
    done_sig = 1'b1; product = 16'h0200;
    step();
    read_req = 1'b1;
    for (int k = 1; k < 40; k++) begin
      product = 16'h0200 + 16'(k);
      step();
      total_cnt++;
      if ({fifo_read_data, read_valid, count, overflow, underflow} !== {16'h0200 + 16'(k - 1), 1'b1, 5'd1, 2'b00})
        $display("FAIL wrap_%0d got %h exp %h", k, {fifo_read_data, read_valid, count, overflow, underflow}, {16'h0200 + 16'(k - 1), 1'b1, 5'd1, 2'b00});
      else pass_cnt++;
    end
    done_sig = 1'b0;
    step();
    read_req = 1'b0;
    total_cnt++;
    if ({fifo_read_data, count} !== {16'h0227, 5'd0}) $display("FAIL wrap_last got %h exp %h", {fifo_read_data, count}, {16'h0227, 5'd0});
    else pass_cnt++;
  endtask

  task automatic test_reset_midstream();
    for (int i = 0; i < 3; i++) begin
      done_sig = 1'b1; product = 16'h0300 + 16'(i);
      step();
    end
    done_sig = 1'b0; read_req = 1'b1;
    step();
    read_req = 1'b0;
    total_cnt++;
    if ({fifo_read_data, read_valid, count} !== {16'h0300, 1'b1, 5'd2}) $display("FAIL pre_reset got %h exp %h", {fifo_read_data, read_valid, count}, {16'h0300, 1'b1, 5'd2});
    else pass_cnt++;
    #2 rst = 1'b1;
    #1;
    total_cnt++;
    if ({fifo_read_data, read_valid, count, empty_out} !== {16'h0000, 1'b0, 5'd0, 1'b1}) $display("FAIL async_reset got %h exp %h", {fifo_read_data, read_valid, count, empty_out}, {16'h0000, 1'b0, 5'd0, 1'b1});
    else pass_cnt++;
    step();
    rst = 1'b0;
    read_req = 1'b1;
    step();
    read_req = 1'b0;
    total_cnt++;
    if ({read_valid, underflow, empty_out} !== 3'b011) $display("FAIL post_reset got %b exp 011", {read_valid, underflow, empty_out});
    else pass_cnt++;
  endtask

  initial begin
    test_reset();
    test_single();
    test_fill_overflow();
    test_simultaneous();
    test_err_clr();
    test_wrap();
    test_reset_midstream();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end
endmodule
